// File: rtl/console_mc_if.sv
// Console bus: ADC fs/fd handshakes, com receiver/transmitter handshakes and latched reply data.
interface console_mc_if #(
    parameter int unsigned NCH = 4
);
    logic             fs_adc_init;
    logic             fs_adc_type;
    logic             fs_adc_conf;
    logic             fs_adc_conv;
    logic             fs_adc_send;
    logic [NCH-1:0]   fd_adc_init;
    logic [NCH-1:0]   fd_adc_type;
    logic [NCH-1:0]   fd_adc_conf;
    logic [NCH-1:0]   fd_adc_conv;
    logic [NCH-1:0]   fd_adc_send;
    logic [NCH-1:0]   chan_en;
    logic             fs_com_send;
    logic             fd_com_send;
    logic             fs_com_read;
    logic             fd_com_read;
    logic [3:0]       read_btype;
    logic [7:0]       read_data;
    logic [3:0]       send_btype;
    logic [NCH*8-1:0] adc_type;
    logic [NCH*16-1:0] adc_temp;
    logic [3:0]       adc_freq;
    logic [NCH*8-1:0] com_type;
    logic [NCH*8-1:0] com_temp;
    logic [7:0]       com_stat;
    logic [7:0]       com_ddidx;

    modport master (
        output fs_adc_init, fs_adc_type, fs_adc_conf, fs_adc_conv, fs_adc_send,
        output chan_en, fs_com_send, fd_com_read, send_btype, adc_freq,
        output com_type, com_temp, com_stat, com_ddidx,
        input  fd_adc_init, fd_adc_type, fd_adc_conf, fd_adc_conv, fd_adc_send,
        input  fd_com_send, fs_com_read, read_btype, read_data, adc_type, adc_temp
    );

    modport slave (
        input  fs_adc_init, fs_adc_type, fs_adc_conf, fs_adc_conv, fs_adc_send,
        input  chan_en, fs_com_send, fd_com_read, send_btype, adc_freq,
        input  com_type, com_temp, com_stat, com_ddidx,
        output fd_adc_init, fd_adc_type, fd_adc_conf, fd_adc_conv, fd_adc_send,
        output fd_com_send, fs_com_read, read_btype, read_data, adc_type, adc_temp
    );
endinterface

// File: rtl/console_mc.sv
// Multi-channel console sequencer: decodes com packets, runs NCH ADC front-ends
// in parallel through fs/fd handshakes and requests the matching reply packet.
module console_mc #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned TW      = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic         clk,
    input  logic         rst,
    console_mc_if.master bus
);
    localparam logic [3:0]    PK_DIDX   = 4'b0101;
    localparam logic [3:0]    PK_DPARAM = 4'b0110;
    localparam logic [3:0]    PK_DDIDX  = 4'b0111;
    localparam logic [3:0]    PK_DLINK  = 4'b1000;
    localparam logic [3:0]    PK_DTYPE  = 4'b1001;
    localparam logic [3:0]    PK_DTEMP  = 4'b1010;
    localparam logic [3:0]    PK_DATA0  = 4'b1101;
    localparam logic [3:0]    PK_DERR   = 4'b1111;
    localparam logic [TW-1:0] CNT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LINK_WORK, S_LINK_TAKE, S_LINK_SEND, S_WAIT, S_TAKE,
        S_ACK, S_OP_WORK, S_OP_TAKE, S_OP_SEND, S_DONE
    } state_e;

    typedef enum logic [1:0] { OP_TYPE, OP_CONF, OP_CONV, OP_ERR } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [NCH-1:0]   chan_en_q, chan_en_d;
    logic [3:0]       adc_freq_q, adc_freq_d;
    logic [3:0]       send_btype_q, send_btype_d;
    logic [NCH*8-1:0] com_type_q, com_type_d;
    logic [NCH*8-1:0] com_temp_q, com_temp_d;
    logic [7:0]       com_stat_q, com_stat_d;
    logic [7:0]       com_ddidx_q, com_ddidx_d;
    logic             com_seen_q, com_seen_d;
    logic [NCH-1:0]   send_seen_q, send_seen_d;
    logic             fs_init_q, fs_init_d, fs_type_q, fs_type_d;
    logic             fs_conf_q, fs_conf_d, fs_conv_q, fs_conv_d;
    logic             fs_send_q, fs_send_d, fs_com_q, fs_com_d;
    logic             fd_read_q, fd_read_d;

    logic             in_work, all_done, timed_out, com_ok, adc_ok;
    logic [NCH-1:0]   fd_sel;

    // Done vector of whichever handshake the current WORK state is waiting on
    always_comb begin
        fd_sel = '0;
        if (state_q == S_LINK_WORK) begin
            fd_sel = bus.fd_adc_init;
        end else if (state_q == S_OP_WORK) begin
            case (op_q)
                OP_TYPE: fd_sel = bus.fd_adc_type;
                OP_CONF: fd_sel = bus.fd_adc_conf;
                OP_CONV: fd_sel = bus.fd_adc_conv;
                default: fd_sel = '0;
            endcase
        end
    end

    assign in_work   = (state_q == S_LINK_WORK) || (state_q == S_OP_WORK);
    assign all_done  = &(fd_sel | ~chan_en_q);
    assign timed_out = (cnt_q == CNT_LAST);
    assign com_ok    = com_seen_q | bus.fd_com_send;
    assign adc_ok    = (op_q != OP_CONV) | (&(send_seen_q | bus.fd_adc_send | ~chan_en_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_TYPE;
            cnt_q        <= '0;
            chan_en_q    <= '1;
            adc_freq_q   <= '0;
            send_btype_q <= '0;
            com_type_q   <= '0;
            com_temp_q   <= '0;
            com_stat_q   <= '0;
            com_ddidx_q  <= '0;
            com_seen_q   <= 1'b0;
            send_seen_q  <= '0;
            fs_init_q    <= 1'b0;
            fs_type_q    <= 1'b0;
            fs_conf_q    <= 1'b0;
            fs_conv_q    <= 1'b0;
            fs_send_q    <= 1'b0;
            fs_com_q     <= 1'b0;
            fd_read_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            chan_en_q    <= chan_en_d;
            adc_freq_q   <= adc_freq_d;
            send_btype_q <= send_btype_d;
            com_type_q   <= com_type_d;
            com_temp_q   <= com_temp_d;
            com_stat_q   <= com_stat_d;
            com_ddidx_q  <= com_ddidx_d;
            com_seen_q   <= com_seen_d;
            send_seen_q  <= send_seen_d;
            fs_init_q    <= fs_init_d;
            fs_type_q    <= fs_type_d;
            fs_conf_q    <= fs_conf_d;
            fs_conv_q    <= fs_conv_d;
            fs_send_q    <= fs_send_d;
            fs_com_q     <= fs_com_d;
            fd_read_q    <= fd_read_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_LINK_WORK;
            S_LINK_WORK: if (all_done || timed_out) state_d = S_LINK_TAKE;
            S_LINK_TAKE: state_d = S_LINK_SEND;
            S_LINK_SEND: if (com_ok) state_d = S_WAIT;
            S_WAIT:      if (bus.fs_com_read) state_d = S_TAKE;
            S_TAKE:      state_d = S_ACK;
            S_ACK:       if (!bus.fs_com_read) state_d = (op_q == OP_ERR) ? S_OP_TAKE : S_OP_WORK;
            S_OP_WORK:   if (all_done || timed_out) state_d = S_OP_TAKE;
            S_OP_TAKE:   state_d = S_OP_SEND;
            S_OP_SEND:   if (com_ok && adc_ok) state_d = S_DONE;
            S_DONE:      state_d = S_WAIT;
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath updates plus strobes registered from the upcoming state
    always_comb begin
        op_d         = op_q;
        cnt_d        = '0;
        chan_en_d    = chan_en_q;
        adc_freq_d   = adc_freq_q;
        send_btype_d = send_btype_q;
        com_type_d   = com_type_q;
        com_temp_d   = com_temp_q;
        com_stat_d   = com_stat_q;
        com_ddidx_d  = com_ddidx_q;
        com_seen_d   = com_seen_q;
        send_seen_d  = send_seen_q;

        if (in_work) cnt_d = cnt_q + TW'(1);
        if (in_work && timed_out && !all_done) begin
            for (int i = 0; i < NCH; i++) com_stat_d[i] = chan_en_q[i] & ~fd_sel[i];
        end

        case (state_q)
            S_TAKE: begin
                com_stat_d = '0;
                case (bus.read_btype)
                    PK_DIDX: begin
                        chan_en_d = (bus.read_data[NCH-1:0] == '0) ? '1 : bus.read_data[NCH-1:0];
                        op_d      = OP_TYPE;
                    end
                    PK_DPARAM: begin
                        adc_freq_d = bus.read_data[3:0];
                        op_d       = OP_CONF;
                    end
                    PK_DDIDX: begin
                        com_ddidx_d = bus.read_data;
                        op_d        = OP_CONV;
                    end
                    default: begin
                        com_stat_d[7] = 1'b1;
                        op_d          = OP_ERR;
                    end
                endcase
            end
            S_LINK_TAKE: begin
                send_btype_d = PK_DLINK;
                com_seen_d   = 1'b0;
            end
            S_OP_TAKE: begin
                com_seen_d  = 1'b0;
                send_seen_d = '0;
                case (op_q)
                    OP_TYPE: begin
                        send_btype_d = PK_DTYPE;
                        for (int i = 0; i < NCH; i++)
                            com_type_d[i*8 +: 8] = chan_en_q[i] ? bus.adc_type[i*8 +: 8] : 8'h00;
                    end
                    OP_CONF: begin
                        send_btype_d = PK_DTEMP;
                        for (int i = 0; i < NCH; i++)
                            com_temp_d[i*8 +: 8] = chan_en_q[i] ? bus.adc_temp[i*16 +: 8] : 8'h00;
                    end
                    OP_CONV: send_btype_d = PK_DATA0;
                    default: send_btype_d = PK_DERR;
                endcase
            end
            S_LINK_SEND: com_seen_d = com_seen_q | bus.fd_com_send;
            S_OP_SEND: begin
                com_seen_d  = com_seen_q | bus.fd_com_send;
                send_seen_d = send_seen_q | bus.fd_adc_send;
            end
            S_DONE:  send_btype_d = '0;
            default: ;
        endcase

        fs_init_d = (state_d == S_LINK_WORK);
        fs_type_d = (state_d == S_OP_WORK) && (op_d == OP_TYPE);
        fs_conf_d = (state_d == S_OP_WORK) && (op_d == OP_CONF);
        fs_conv_d = (state_d == S_OP_WORK) && (op_d == OP_CONV);
        fs_send_d = (state_d == S_OP_SEND) && (op_d == OP_CONV);
        fs_com_d  = (state_d == S_LINK_SEND) || (state_d == S_OP_SEND);
        fd_read_d = (state_d == S_ACK);
    end

    assign bus.fs_adc_init = fs_init_q;
    assign bus.fs_adc_type = fs_type_q;
    assign bus.fs_adc_conf = fs_conf_q;
    assign bus.fs_adc_conv = fs_conv_q;
    assign bus.fs_adc_send = fs_send_q;
    assign bus.fs_com_send = fs_com_q;
    assign bus.fd_com_read = fd_read_q;
    assign bus.chan_en     = chan_en_q;
    assign bus.send_btype  = send_btype_q;
    assign bus.adc_freq    = adc_freq_q;
    assign bus.com_type    = com_type_q;
    assign bus.com_temp    = com_temp_q;
    assign bus.com_stat    = com_stat_q;
    assign bus.com_ddidx   = com_ddidx_q;
endmodule

// File: tb/tb_console_mc.sv
// Randomized bench for console_mc against a packet-level reference model.
module tb_console_mc;
    localparam int NCH     = 4;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    console_mc_if #(.NCH(NCH)) bus ();

    console_mc #(.NCH(NCH), .TW(16), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks;
    int n_errors;

    logic [3:0]  m_chan_en, m_freq;
    logic [31:0] m_type, m_temp;
    logic [7:0]  m_stat, m_ddidx;

    // Per-channel done delay in WORK, send pulse cycle, and com pulse cycle
    int plan_d[NCH];
    int plan_s[NCH];
    int plan_c;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] fs_vec();
        return {bus.fs_adc_send, bus.fs_adc_conv, bus.fs_adc_conf, bus.fs_adc_type, bus.fs_adc_init};
    endfunction

    function automatic logic fs_of(input int sel);
        case (sel)
            0:       return bus.fs_adc_init;
            1:       return bus.fs_adc_type;
            2:       return bus.fs_adc_conf;
            3:       return bus.fs_adc_conv;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_fd(input int sel, input logic [NCH-1:0] v);
        case (sel)
            0:       bus.fd_adc_init = v;
            1:       bus.fd_adc_type = v;
            2:       bus.fd_adc_conf = v;
            3:       bus.fd_adc_conv = v;
            default: ;
        endcase
    endtask

    task automatic clear_inputs();
        bus.fd_adc_init = '0;
        bus.fd_adc_type = '0;
        bus.fd_adc_conf = '0;
        bus.fd_adc_conv = '0;
        bus.fd_adc_send = '0;
        bus.fd_com_send = 1'b0;
        bus.fs_com_read = 1'b0;
        bus.read_btype  = '0;
        bus.read_data   = '0;
    endtask

    task automatic rand_adc();
        bus.adc_type = 32'($urandom);
        bus.adc_temp = {32'($urandom), 32'($urandom)};
    endtask

    task automatic rand_plan();
        int r;
        for (int i = 0; i < NCH; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       plan_d[i] = int'($urandom_range(0, 8));
            else if (r == 6) plan_d[i] = TIMEOUT - 1;
            else if (r == 7) plan_d[i] = TIMEOUT;
            else             plan_d[i] = 100;
            plan_s[i] = int'($urandom_range(0, 6));
        end
        plan_c = int'($urandom_range(0, 6));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        check("rst_strobes", {fs_vec(), bus.fs_com_send, bus.fd_com_read}, 0);
        check("rst_chan_en", bus.chan_en, 4'hF);
        check("rst_btype_freq", {bus.send_btype, bus.adc_freq}, 0);
        check("rst_type_temp", {bus.com_type, bus.com_temp}, 0);
        check("rst_stat_ddidx", {bus.com_stat, bus.com_ddidx}, 0);
        m_chan_en = 4'hF; m_freq = '0; m_type = '0; m_temp = '0; m_stat = '0; m_ddidx = '0;
        rst = 1'b0;
    endtask

    // Entered on the first cycle the start strobe is visible; leaves on the TAKE cycle
    task automatic run_work(input int sel);
        int dmax, exp_cyc, k;
        logic [NCH-1:0] flags, fdv;
        logic [4:0] other;
        bit done;
        dmax = 0;
        for (int i = 0; i < NCH; i++)
            if (m_chan_en[i] && plan_d[i] > dmax) dmax = plan_d[i];
        exp_cyc = (dmax < TIMEOUT) ? dmax + 1 : TIMEOUT;
        for (int i = 0; i < NCH; i++)
            flags[i] = m_chan_en[i] && (dmax >= TIMEOUT) && (plan_d[i] >= TIMEOUT);
        other = 5'b11111 & ~(5'(1) << sel);
        check("work_start", fs_of(sel), 1);
        check("work_other_fs", fs_vec() & other, 0);
        k = 0;
        done = 0;
        while (!done && k < TIMEOUT + 5) begin
            for (int i = 0; i < NCH; i++) fdv[i] = (k >= plan_d[i]);
            set_fd(sel, fdv);
            @(negedge clk);
            k++;
            if (!fs_of(sel)) done = 1;
        end
        check("work_cycles", k, exp_cyc);
        set_fd(sel, '0);
        m_stat[NCH-1:0] = m_stat[NCH-1:0] | flags;
    endtask

    // Entered on the first reply-request cycle; leaves in WAIT
    task automatic run_send(input bit is_conv, input bit is_link);
        int m, k;
        bit done;
        logic [NCH-1:0] v;
        m = plan_c;
        if (is_conv)
            for (int i = 0; i < NCH; i++)
                if (m_chan_en[i] && plan_s[i] > m) m = plan_s[i];
        k = 0;
        done = 0;
        while (!done && k < 60) begin
            bus.fd_com_send = (k == plan_c);
            for (int i = 0; i < NCH; i++) v[i] = is_conv ? (k == plan_s[i]) : 1'($urandom);
            bus.fd_adc_send = v;
            @(negedge clk);
            k++;
            if (!bus.fs_com_send) done = 1;
        end
        bus.fd_com_send = 1'b0;
        bus.fd_adc_send = '0;
        check("send_cycles", k, m + 1);
        check("post_send_strobes", {fs_vec(), bus.fs_com_send, bus.fd_com_read}, 0);
        if (!is_link) begin
            @(negedge clk);
            check("done_btype_clear", bus.send_btype, 0);
        end
    endtask

    task automatic run_link(input int dl, input int c);
        for (int i = 0; i < NCH; i++) plan_d[i] = dl;
        plan_c = c;
        @(negedge clk);
        run_work(0);
        check("link_take_no_req", bus.fs_com_send, 0);
        @(negedge clk);
        check("link_req", bus.fs_com_send, 1);
        check("link_btype", bus.send_btype, 4'b1000);
        check("link_stat", bus.com_stat, m_stat);
        run_send(1'b0, 1'b1);
    endtask

    task automatic run_cmd(input logic [3:0] bt, input logic [7:0] data, input int abort);
        int sel, k;
        logic [3:0] exp_bt;
        m_stat = 8'h00;
        case (bt)
            4'b0101: begin m_chan_en = (data[3:0] == 4'h0) ? 4'hF : data[3:0]; sel = 1; exp_bt = 4'b1001; end
            4'b0110: begin m_freq = data[3:0]; sel = 2; exp_bt = 4'b1010; end
            4'b0111: begin m_ddidx = data; sel = 3; exp_bt = 4'b1101; end
            default: begin m_stat[7] = 1'b1; sel = -1; exp_bt = 4'b1111; end
        endcase
        bus.read_btype  = bt;
        bus.read_data   = data;
        bus.fs_com_read = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.fd_com_read && k < 10);
        check("ack_latency", k, 2);
        check("ack_no_fs", fs_vec(), 0);
        check("ack_chan_en", bus.chan_en, m_chan_en);
        check("ack_freq", bus.adc_freq, m_freq);
        check("ack_ddidx", bus.com_ddidx, m_ddidx);
        check("ack_stat", bus.com_stat, m_stat);
        bus.fs_com_read = 1'b0;
        bus.read_btype  = 4'($urandom);
        bus.read_data   = 8'($urandom);
        @(negedge clk);
        check("ack_release", bus.fd_com_read, 0);
        if (abort > 0) begin
            repeat (abort) @(negedge clk);
            check("abort_in_work", fs_of(sel), 1);
            return;
        end
        if (sel >= 0) run_work(sel);
        else          check("err_no_work", fs_vec(), 0);
        check("take_no_req", bus.fs_com_send, 0);
        for (int i = 0; i < NCH; i++) begin
            if (sel == 1) m_type[i*8 +: 8] = m_chan_en[i] ? bus.adc_type[i*8 +: 8] : 8'h00;
            if (sel == 2) m_temp[i*8 +: 8] = m_chan_en[i] ? bus.adc_temp[i*16 +: 8] : 8'h00;
        end
        @(negedge clk);
        check("reply_req", bus.fs_com_send, 1);
        check("reply_btype", bus.send_btype, exp_bt);
        check("reply_stat", bus.com_stat, m_stat);
        check("reply_type", bus.com_type, m_type);
        check("reply_temp", bus.com_temp, m_temp);
        check("reply_adc_send", bus.fs_adc_send, (sel == 3));
        run_send(sel == 3, 1'b0);
    endtask

    task automatic rand_cmd();
        int r, b;
        rand_adc();
        rand_plan();
        r = int'($urandom_range(0, 3));
        if (r == 3) begin
            b = int'($urandom_range(0, 12));
            if (b >= 5) b = b + 3;
            run_cmd(4'(b), 8'($urandom), 0);
        end else begin
            run_cmd(4'(5 + r), 8'($urandom), 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_inputs();
        bus.adc_type = '0;
        bus.adc_temp = '0;
        do_reset();
        run_link(10, 3);

        bus.adc_type = 32'h44332211;
        rand_adc_temp_only: bus.adc_temp = {32'($urandom), 32'($urandom)};
        plan_d = '{2, 100, 4, 100};
        plan_c = 1;
        run_cmd(4'b0101, 8'h05, 0);
        check("tp_didx_type", bus.com_type, 32'h00330011);
        check("tp_didx_mask", bus.chan_en, 4'b0101);

        plan_d = '{3, 100, 100, 5};
        plan_c = 0;
        run_cmd(4'b0110, 8'h07, 0);
        check("tp_dparam_stat", bus.com_stat, 8'h04);
        check("tp_dparam_freq", bus.adc_freq, 4'h7);

        plan_d = '{1, 100, 2, 100};
        plan_s = '{3, 9, 1, 9};
        plan_c = 0;
        run_cmd(4'b0111, 8'h2A, 0);
        check("tp_ddidx", bus.com_ddidx, 8'h2A);

        plan_c = 2;
        run_cmd(4'b0011, 8'h5C, 0);
        check("tp_err_stat", bus.com_stat, 8'h80);

        plan_d = '{1, 1, 1, 1};
        plan_c = 1;
        run_cmd(4'b0101, 8'h00, 0);
        check("tp_zero_mask", bus.chan_en, 4'hF);

        for (int n = 0; n < 40; n++) rand_cmd();

        plan_d = '{100, 100, 100, 100};
        run_cmd(4'b0111, 8'hC3, 4);
        do_reset();
        run_link(5, 0);

        for (int n = 0; n < 10; n++) rand_cmd();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/console_mc.md
Name: console_mc

Overview:
Multi-channel successor of the single-ADC console sequencer. Decodes command packets from the com receiver and drives NCH ADC front-ends in parallel through fs/fd handshakes (link, type, conf, conv, send). Collects per-channel results and requests the matching reply packet from the com transmitter. Adds a per-command channel-enable mask, a completion timeout with per-channel error status, and an error reply for unknown commands.

Parameters:
NCH, 4, number of ADC channels (1..8)
TW, 16, timeout counter width
TIMEOUT, 50000, max cycles waiting for ADC done before abort (must be < 2^TW)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
fs_adc_init  out  1  start link/init on enabled channels
fs_adc_type  out  1  start type read
fs_adc_conf  out  1  start configuration
fs_adc_conv  out  1  start conversion
fs_adc_send  out  1  start data streaming
fd_adc_init  in  NCH  per-channel init done
fd_adc_type  in  NCH  per-channel type done
fd_adc_conf  in  NCH  per-channel conf done
fd_adc_conv  in  NCH  per-channel conv done
fd_adc_send  in  NCH  per-channel send done
chan_en  out  NCH  active channel mask
fs_com_send  out  1  request reply packet
fd_com_send  in  1  reply packet sent
fs_com_read  in  1  command packet available
fd_com_read  out  1  command accepted
read_btype  in  4  received packet type
read_data  in  8  received packet payload
send_btype  out  4  reply packet type
adc_type  in  NCH*8  per-channel type bytes
adc_temp  in  NCH*16  per-channel temperature
adc_freq  out  4  sample-rate code to ADCs
com_type  out  NCH*8  latched types
com_temp  out  NCH*8  latched temperature low bytes
com_stat  out  8  [NCH-1:0] per-channel timeout flags, bit 7 = unknown-command flag
com_ddidx  out  8  latched data index

Behaviour:
- Reset (on rst at clk edge, from any state, aborts any operation): state IDLE; all fs_* low, fd_com_read low; chan_en = all ones; send_btype 0000; adc_freq 0; com_type, com_temp, com_stat, com_ddidx 0; timeout counter 0.
- Packet codes: in DIDX 0101, DPARAM 0110, DDIDX 0111. Out DLINK 1000, DTYPE 1001, DTEMP 1010, DATA0 1101, DERR 1111.
- States: IDLE -> LINK_WORK -> LINK_TAKE -> LINK_SEND -> WAIT -> TAKE -> ACK -> OP_WORK -> OP_TAKE -> OP_SEND -> DONE -> WAIT. A 2-bit op register (TYPE/CONF/CONV/ERR) selects which fs_adc_* OP_WORK drives.
- fs_adc_init is high only in LINK_WORK. fs_adc_type/conf/conv are high only in OP_WORK for the matching op. fs_adc_send is high in OP_SEND when op = CONV. fs_com_send is high in LINK_SEND and OP_SEND. fd_com_read is high only in ACK.
- WORK exit: all_done = &(fd_x | ~chan_en). When all_done, go to TAKE next cycle. The counter increments each WORK cycle and clears on entry. When it reaches TIMEOUT-1 without all_done: com_stat[i] <= chan_en[i] & ~fd_x[i], then go to TAKE. If all_done and timeout coincide, all_done wins and no flags are set.
- WAIT: when fs_com_read, go to TAKE. TAKE latches on read_btype:
  - DIDX: chan_en <= read_data[NCH-1:0], op = TYPE.
  - DPARAM: adc_freq <= read_data[3:0], op = CONF.
  - DDIDX: com_ddidx <= read_data, op = CONV.
  - Other: com_stat[7] <= 1, op = ERR.
  - A DIDX mask of 0 is replaced by all ones.
- ACK: hold fd_com_read until fs_com_read is low. Op ERR then skips WORK and goes to OP_TAKE.
- OP_TAKE / LINK_TAKE: send_btype <= DTYPE (TYPE, com_type <= adc_type), DTEMP (CONF, com_temp[i] <= adc_temp[i][7:0]), DATA0 (CONV), DERR (ERR), DLINK (link). Disabled channels' lanes load 0.
- OP_SEND: exit when fd_com_send, and for CONV also when all enabled fd_adc_send are set. The signals may arrive in different cycles; each is tracked in a sticky flag cleared on OP_TAKE.
- DONE: send_btype <= 0. com_stat clears on the next TAKE.
- Latency: fs_adc_* rises 1 cycle after ACK exits; the reply request rises 2 cycles after WORK completes.

Test Plan:
- Reset, NCH=4, all fd_adc_init rise at cycle 10, fd_com_send at cycle 15 -> send_btype=1000 during LINK_SEND, then WAIT with all fs low.
- DIDX, read_data=8'h05, adc_type={8'h44,8'h33,8'h22,8'h11}, fd_adc_type=4'b0101 -> chan_en=0101, com_type=32'h00330011, send_btype=1001, com_stat=0.
- DPARAM, read_data=8'h07, channel 2 never done, TIMEOUT=20 -> adc_freq=7, exactly 20 cycles in WORK, com_stat=8'h04, send_btype=1010.
- DDIDX, read_data=8'h2A, fd_com_send 3 cycles before the last fd_adc_send -> com_ddidx=8'h2A, fs_com_send held until both seen, send_btype=1101.
- read_btype=4'b0011 -> no fs_adc pulse, com_stat=8'h80, send_btype=1111, return to WAIT.
- rst asserted mid-CONV WORK -> next cycle all outputs at reset values; link sequence restarts.
